// File: rtl/dram_bridge_arb.sv
// dram_bridge_arb: round-robin arbiter bridging NUM_CH single-outstanding client channels onto
// one AXI4-Lite master port. Only one AXI transaction is in flight at a time.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   C_in_valid/C_r_wb            per-channel request strobe and read(1)/write(0) select
//   C_addr/C_data_w              packed per-channel address / write data
//   C_busy                       channel holds a pending or in-flight request
//   C_out_valid                  one-hot, one-cycle completion pulse
//   C_data_r/C_err               read data and response-error flag of the completing channel
//   AR/R/AW/W/B channels         AXI4-Lite master, all outputs registered
module dram_bridge_arb #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        C_in_valid,
  input  logic [NUM_CH-1:0]        C_r_wb,
  input  logic [NUM_CH*ADDR_W-1:0] C_addr,
  input  logic [NUM_CH*DATA_W-1:0] C_data_w,
  output logic [NUM_CH-1:0]        C_busy,
  output logic [NUM_CH-1:0]        C_out_valid,
  output logic [DATA_W-1:0]        C_data_r,
  output logic                     C_err,
  output logic                     AR_VALID,
  output logic [ADDR_W-1:0]        AR_ADDR,
  input  logic                     AR_READY,
  input  logic                     R_VALID,
  input  logic [DATA_W-1:0]        R_DATA,
  input  logic [1:0]               R_RESP,
  output logic                     R_READY,
  output logic                     AW_VALID,
  output logic [ADDR_W-1:0]        AW_ADDR,
  input  logic                     AW_READY,
  output logic                     W_VALID,
  output logic [DATA_W-1:0]        W_DATA,
  input  logic                     W_READY,
  input  logic                     B_VALID,
  input  logic [1:0]               B_RESP,
  output logic                     B_READY
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB, StDone} state_e;

  state_e              state_q;
  logic [NUM_CH-1:0]   pending_q;
  logic [NUM_CH-1:0]   r_wb_q;
  logic [ADDR_W-1:0]   addr_q [NUM_CH];
  logic [DATA_W-1:0]   data_q [NUM_CH];
  logic [ChW-1:0]      grant_q;
  logic [ChW-1:0]      last_grant_q;

  logic                grant_any;
  logic [ChW-1:0]      grant_idx;
  logic [ChW:0]        cand;
  logic [NUM_CH-1:0]   done_clr;

  assign C_busy = pending_q;

  // Pending bit of the granted channel retires during the DONE cycle.
  always_comb begin
    done_clr = '0;
    if (state_q == StDone) done_clr[grant_q] = 1'b1;
  end

  // Round-robin: first pending channel after last_grant, wrapping modulo NUM_CH.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      cand = {1'b0, last_grant_q} + (ChW+1)'(off);
      if (cand >= (ChW+1)'(NUM_CH)) cand = cand - (ChW+1)'(NUM_CH);
      if (!grant_any && pending_q[cand[ChW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[ChW-1:0];
      end
    end
  end

  // Request capture. A strobe in the channel's own DONE cycle is accepted (clear-then-set);
  // any other strobe while pending is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      r_wb_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (C_in_valid[i] && (!pending_q[i] || done_clr[i])) begin
          pending_q[i] <= 1'b1;
          r_wb_q[i]    <= C_r_wb[i];
          addr_q[i]    <= C_addr[i*ADDR_W +: ADDR_W];
          data_q[i]    <= C_data_w[i*DATA_W +: DATA_W];
        end else if (done_clr[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  // Transaction FSM with registered AXI and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= ChW'(NUM_CH - 1);
      C_out_valid  <= '0;
      C_data_r     <= '0;
      C_err        <= 1'b0;
      AR_VALID     <= 1'b0;
      AR_ADDR      <= '0;
      R_READY      <= 1'b0;
      AW_VALID     <= 1'b0;
      AW_ADDR      <= '0;
      W_VALID      <= 1'b0;
      W_DATA       <= '0;
      B_READY      <= 1'b0;
    end else begin
      // Completion outputs are single-cycle; only the R/B exit re-arms them.
      C_out_valid <= '0;
      C_data_r    <= '0;
      C_err       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_any) begin
            grant_q      <= grant_idx;
            last_grant_q <= grant_idx;
            if (r_wb_q[grant_idx]) begin
              state_q  <= StAr;
              AR_VALID <= 1'b1;
              AR_ADDR  <= addr_q[grant_idx];
            end else begin
              state_q  <= StAw;
              AW_VALID <= 1'b1;
              AW_ADDR  <= addr_q[grant_idx];
            end
          end
        end
        StAr: begin
          if (AR_READY) begin
            AR_VALID <= 1'b0;
            AR_ADDR  <= '0;
            R_READY  <= 1'b1;
            state_q  <= StR;
          end
        end
        StR: begin
          if (R_VALID) begin
            R_READY              <= 1'b0;
            C_out_valid[grant_q] <= 1'b1;
            C_data_r             <= R_DATA;
            C_err                <= |R_RESP;
            state_q              <= StDone;
          end
        end
        StAw: begin
          if (AW_READY) begin
            AW_VALID <= 1'b0;
            AW_ADDR  <= '0;
            W_VALID  <= 1'b1;
            W_DATA   <= data_q[grant_q];
            state_q  <= StW;
          end
        end
        StW: begin
          if (W_READY) begin
            W_VALID <= 1'b0;
            W_DATA  <= '0;
            B_READY <= 1'b1;
            state_q <= StB;
          end
        end
        StB: begin
          if (B_VALID) begin
            B_READY              <= 1'b0;
            C_out_valid[grant_q] <= 1'b1;
            C_err                <= |B_RESP;
            state_q              <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
